// File: rtl/echo_range_tracker_if.sv
// Echo range tracker bus: waveform/strobe inputs and detection/range results.
interface echo_range_tracker_if #(
  parameter int SAMPLE_W = 16,
  parameter int TIME_W   = 24
);
  logic                       burst_start_in;
  logic                       sample_valid_in;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic        [SAMPLE_W-1:0] envelope_out;
  logic                       echo_active_out;
  logic                       busy_out;
  logic        [TIME_W-1:0]   tof_cycles_out;
  logic        [15:0]         range_out;
  logic                       valid_out;
  logic                       no_echo_out;

  // Source side: pulse timer / beamformer, consumer of results.
  modport master (
    output burst_start_in, sample_valid_in, sample_in,
    input  envelope_out, echo_active_out, busy_out, tof_cycles_out,
           range_out, valid_out, no_echo_out
  );

  // Tracker side.
  modport slave (
    input  burst_start_in, sample_valid_in, sample_in,
    output envelope_out, echo_active_out, busy_out, tof_cycles_out,
           range_out, valid_out, no_echo_out
  );
endinterface

// File: rtl/echo_range_tracker.sv
// Echo range tracker: moving-average magnitude envelope, blanking window,
// hysteresis detection with a consecutive-sample qualifier, first-echo
// timestamp and time-of-flight to millimetre range conversion.
module echo_range_tracker #(
  parameter int SAMPLE_W        = 16,
  parameter int AVG_LOG2        = 3,
  parameter int THRESH_HI       = 5000,
  parameter int THRESH_LO       = 3000,
  parameter int HOLD_SAMPLES    = 4,
  parameter int BLANK_CYCLES    = 2000,
  parameter int MAX_WAIT_CYCLES = 1000000,
  parameter int TIME_W          = 24,
  parameter int RANGE_MULT      = 1798,
  parameter int RANGE_SHIFT     = 20
) (
  input logic clk_in,
  input logic rst_in,
  echo_range_tracker_if.slave bus
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int MAG_W  = SAMPLE_W - 1;
  localparam int SUM_W  = MAG_W + AVG_LOG2;
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam int PROD_W = TIME_W + 32;

  localparam logic [SAMPLE_W-1:0] HI_L    = SAMPLE_W'(THRESH_HI);
  localparam logic [SAMPLE_W-1:0] LO_L    = SAMPLE_W'(THRESH_LO);
  localparam logic [TIME_W-1:0]   BLANK_T = TIME_W'(BLANK_CYCLES);
  localparam logic [TIME_W-1:0]   MAX_T   = TIME_W'(MAX_WAIT_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_T  = HOLD_W'(HOLD_SAMPLES);
  localparam logic [PROD_W-1:0]   MULT_L  = PROD_W'(RANGE_MULT);

  typedef enum logic [2:0] {IDLE, BLANK, LISTEN, CONV1, CONV2} state_t;

  // |s| with the most negative code clamped so it fits in MAG_W bits.
  function automatic logic [MAG_W-1:0] mag_sat(input logic signed [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] neg;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {MAG_W{1'b1}};
    if (s < 0) begin
      neg = -s;
      return neg[MAG_W-1:0];
    end
    return s[MAG_W-1:0];
  endfunction

  // Scale the registered product down and clamp to the 16-bit range field.
  function automatic logic [15:0] range_sat(input logic [PROD_W-1:0] p);
    logic [PROD_W-1:0] sh;
    sh = p >> RANGE_SHIFT;
    if (|sh[PROD_W-1:16]) return 16'hFFFF;
    return sh[15:0];
  endfunction

  // Envelope datapath
  logic [MAG_W-1:0]    buf_q [DEPTH];
  logic [AVG_LOG2-1:0] ptr_q;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [SAMPLE_W-1:0] env_q;
  logic                env_upd_q;
  logic [MAG_W-1:0]    mag;

  assign mag   = mag_sat(bus.sample_in);
  assign sum_d = sum_q + SUM_W'(mag) - SUM_W'(buf_q[ptr_q]);

  // Sliding-window sum and registered envelope; a new burst starts from empty.
  always_ff @(posedge clk_in) begin
    if (rst_in || bus.burst_start_in) begin
      sum_q     <= '0;
      ptr_q     <= '0;
      env_q     <= '0;
      env_upd_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      env_upd_q <= bus.sample_valid_in;
      if (bus.sample_valid_in) begin
        sum_q        <= sum_d;
        buf_q[ptr_q] <= mag;
        ptr_q        <= ptr_q + 1'b1;
        env_q        <= SAMPLE_W'(sum_d >> AVG_LOG2);
      end
    end
  end

  // Detection / conversion control
  state_t              state_q, state_d;
  logic [TIME_W-1:0]   timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TIME_W-1:0]   cand_q, cand_d;
  logic                echo_q, echo_d;
  logic                confirm, no_echo, load;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [TIME_W-1:0]   tof_q;
  logic [15:0]         range_q;
  logic                valid_q;

  assign prod_d = PROD_W'(cand_d) * MULT_L;
  assign load   = (state_q == CONV1) && !bus.burst_start_in;

  // Next-state: blanking, hysteresis qualifier, timeout; a burst restarts everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    cand_d  = cand_q;
    echo_d  = 1'b0;
    confirm = 1'b0;
    no_echo = 1'b0;
    if (state_q != IDLE && timer_q != '1) timer_d = timer_q + 1'b1;
    case (state_q)
      BLANK: begin
        if (timer_q == BLANK_T) state_d = LISTEN;
        if (timer_q == MAX_T) begin
          state_d = IDLE;
          no_echo = 1'b1;
        end
      end
      LISTEN: begin
        echo_d = echo_q;
        if (env_upd_q) begin
          if (env_q >= HI_L) begin
            if (hold_q == '0) cand_d = timer_q;
            hold_d = hold_q + 1'b1;
            echo_d = 1'b1;
            if (hold_d == HOLD_T) confirm = 1'b1;
          end else if (env_q < LO_L) begin
            hold_d = '0;
            echo_d = 1'b0;
          end
        end
        if (confirm) begin
          state_d = CONV1;
          hold_d  = '0;
        end else if (timer_q == MAX_T) begin
          state_d = IDLE;
          no_echo = 1'b1;
        end
      end
      CONV1:   state_d = CONV2;
      CONV2:   state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (bus.burst_start_in) begin
      state_d = BLANK;
      timer_d = TIME_W'(1);
      hold_d  = '0;
      echo_d  = 1'b0;
      confirm = 1'b0;
      no_echo = 1'b0;
    end
  end

  // Control registers, product stage and result registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      cand_q  <= '0;
      echo_q  <= 1'b0;
      prod_q  <= '0;
      tof_q   <= '0;
      range_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      cand_q  <= cand_d;
      echo_q  <= echo_d;
      // stage 1: tof x scale captured on the confirming update
      if (confirm) prod_q <= prod_d;
      // stage 2: scaled, saturated range published with the timestamp
      if (load) begin
        tof_q   <= cand_q;
        range_q <= range_sat(prod_q);
      end
      valid_q <= load;
    end
  end

  assign bus.envelope_out    = env_q;
  assign bus.echo_active_out = echo_q && (state_q == LISTEN);
  assign bus.busy_out        = (state_q != IDLE);
  assign bus.tof_cycles_out  = tof_q;
  assign bus.range_out       = range_q;
  assign bus.valid_out       = valid_q;
  assign bus.no_echo_out     = no_echo;

endmodule

// File: tb/tb_echo_range_tracker.sv
// Directed bench for echo_range_tracker with hand-computed expectations.
module tb_echo_range_tracker;
  localparam int SW = 16;
  localparam int TW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  echo_range_tracker_if #(.SAMPLE_W(SW), .TIME_W(TW)) bus ();

  echo_range_tracker #(
    .SAMPLE_W(SW), .AVG_LOG2(2), .THRESH_HI(5000), .THRESH_LO(3000),
    .HOLD_SAMPLES(3), .BLANK_CYCLES(10), .MAX_WAIT_CYCLES(200),
    .TIME_W(TW), .RANGE_MULT(1000), .RANGE_SHIFT(4)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int scen  = 0;
  int valid_cnt, valid_cyc, noecho_cnt, noecho_cyc, busy_fall;
  logic [TW-1:0] rec_tof;
  logic [15:0]   rec_rng;
  logic [15:0]   env_tr  [0:299];
  logic          echo_tr [0:299];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [SW-1:0] sample_for(input int s, input int c);
    int t;
    t = 0;
    case (s)
      2: t = (c >= 50) ? 8000 : 0;
      3: t = ((c >= 1 && c <= 8) || c >= 50) ? 8000 : 0;
      4: t = (c == 50 || c == 51) ? 8000 : 0;
      5: t = (c >= 50 && c < 56) ? 8000 : 0;
      6: t = (c >= 50) ? -8000 : 0;
      7: t = -32768;
      default: t = 0;
    endcase
    return 16'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.sample_in = sample_for(scen, cyc);
    if (cyc < 300) begin
      env_tr[cyc]  = bus.envelope_out;
      echo_tr[cyc] = bus.echo_active_out;
    end
    if (bus.valid_out) begin
      valid_cnt++;
      if (valid_cyc < 0) begin
        valid_cyc = cyc;
        rec_tof   = bus.tof_cycles_out;
        rec_rng   = bus.range_out;
      end
    end
    if (bus.no_echo_out) begin
      noecho_cnt++;
      if (noecho_cyc < 0) noecho_cyc = cyc;
    end
    if (!bus.busy_out && busy_fall < 0) busy_fall = cyc;
  endtask

  task automatic start_burst(input int s);
    scen       = s;
    cyc        = 0;
    valid_cnt  = 0;
    valid_cyc  = -1;
    noecho_cnt = 0;
    noecho_cyc = -1;
    busy_fall  = -1;
    bus.sample_in      = sample_for(s, 0);
    bus.burst_start_in = 1'b1;
    tick();
    bus.burst_start_in = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.burst_start_in  = 1'b0;
    bus.sample_valid_in = 1'b0;
    bus.sample_in       = '0;

    // 1. Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      bus.burst_start_in  = 1'($urandom_range(0, 1));
      bus.sample_valid_in = 1'($urandom_range(0, 1));
      bus.sample_in       = 16'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_envelope", bus.envelope_out, 0);
    chk("rst_echo", bus.echo_active_out, 0);
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_tof", bus.tof_cycles_out, 0);
    chk("rst_range", bus.range_out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_noecho", bus.no_echo_out, 0);
    rst = 1'b0;
    bus.burst_start_in  = 1'b0;
    bus.sample_valid_in = 1'b1;
    bus.sample_in       = '0;
    scen = 0;
    repeat (3) tick();

    // 2. Normal echo
    start_burst(2);
    chk("s2_busy_c1", bus.busy_out, 1);
    run_to(210);
    chk("s2_env51", env_tr[51], 2000);
    chk("s2_env52", env_tr[52], 4000);
    chk("s2_env53", env_tr[53], 6000);
    chk("s2_echo30", echo_tr[30], 0);
    chk("s2_echo55", echo_tr[55], 1);
    chk("s2_valid_cyc", valid_cyc, 57);
    chk("s2_valid_cnt", valid_cnt, 1);
    chk("s2_tof", rec_tof, 53);
    chk("s2_range", rec_rng, 3312);
    chk("s2_busy_fall", busy_fall, 58);
    chk("s2_noecho_cnt", noecho_cnt, 0);

    // 3. Ring-down inside the blanking window
    start_burst(3);
    run_to(60);
    chk("s3_env5", env_tr[5], 8000);
    chk("s3_echo5_blank", echo_tr[5], 0);
    chk("s3_valid_cyc", valid_cyc, 57);
    chk("s3_tof", rec_tof, 53);
    chk("s3_range", rec_rng, 3312);

    // 4. Short glitch, then timeout
    start_burst(4);
    run_to(205);
    chk("s4_env53", env_tr[53], 4000);
    chk("s4_valid_cnt", valid_cnt, 0);
    chk("s4_noecho_cyc", noecho_cyc, 200);
    chk("s4_noecho_cnt", noecho_cnt, 1);
    chk("s4_busy_fall", busy_fall, 201);
    chk("s4_range_kept", bus.range_out, 3312);
    chk("s4_tof_kept", bus.tof_cycles_out, 53);

    // 5. Second burst while converting aborts the result
    start_burst(5);
    run_to(56);
    bus.burst_start_in = 1'b1;
    tick();
    bus.burst_start_in = 1'b0;
    chk("s5_busy57", bus.busy_out, 1);
    run_to(260);
    chk("s5_valid_cnt", valid_cnt, 0);
    chk("s5_noecho_cyc", noecho_cyc, 256);
    chk("s5_noecho_cnt", noecho_cnt, 1);

    // 6. Negative waveform and most-negative clamp
    start_burst(6);
    run_to(60);
    chk("s6_valid_cyc", valid_cyc, 57);
    chk("s6_tof", rec_tof, 53);
    chk("s6_range", rec_rng, 3312);
    scen = 7;
    bus.sample_in = sample_for(7, cyc);
    repeat (6) tick();
    chk("s6_env_minneg", bus.envelope_out, 32767);
    chk("s6_idle_busy", bus.busy_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/echo_range_tracker.md
Name: echo_range_tracker

Overview:
- Sits between the receive beamformer and the range display path.
- Takes the aggregated receive waveform and the burst-start strobe from the pulse timer, and forms a moving-average magnitude envelope.
- Applies a blanking window (to ignore transmitter ring-down) and a hysteresis threshold with a consecutive-sample qualifier, then timestamps the first echo of each burst.
- Converts time of flight to range in mm. It reports either one valid range pulse or one no-echo pulse per burst.

Parameters:
- SAMPLE_W, 16, width of signed input samples.
- AVG_LOG2, 3, envelope window = 2^AVG_LOG2 samples.
- THRESH_HI, 5000, envelope level that qualifies an echo sample.
- THRESH_LO, 3000, envelope level below which a pending qualification is discarded. Must be ≤ THRESH_HI.
- HOLD_SAMPLES, 4, consecutive qualifying envelope updates required to confirm an echo.
- BLANK_CYCLES, 2000, cycles after burst start during which detection is disabled.
- MAX_WAIT_CYCLES, 1000000, cycles after burst start at which listening times out.
- TIME_W, 24, timer / tof width.
- RANGE_MULT, 1798, range scale numerator. Default gives 0.001715 mm/cycle at 100 MHz.
- RANGE_SHIFT, 20, range scale right shift.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- burst_start_in  input  1  one-cycle strobe at start of each transmit burst.
- sample_valid_in  input  1  sample_in is valid this cycle.
- sample_in  input  SAMPLE_W  signed two's-complement aggregated waveform.
- envelope_out  output  SAMPLE_W  registered moving-average magnitude (unsigned).
- echo_active_out  output  1  hysteresis comparator level.
- busy_out  output  1  high from the cycle after burst start until a result is issued.
- tof_cycles_out  output  TIME_W  timer value at the first qualifying sample of the confirmed echo.
- range_out  output  16  range in mm, saturated.
- valid_out  output  1  one-cycle pulse: tof_cycles_out / range_out updated.
- no_echo_out  output  1  one-cycle pulse: timeout without an echo.

Behaviour:
- Reset: every output is 0; FSM is IDLE; timer, hold count, envelope sum and window buffer are cleared.

Timer:
- The cycle burst_start_in is sampled is timer 0; timer reads 1 the next cycle.
- Increments every cycle while not IDLE; saturates at all-ones.

Envelope:
- On sample_valid_in, mag = |sample_in|, with -2^(SAMPLE_W-1) mapped to 2^(SAMPLE_W-1)-1.
- The running sum adds mag and subtracts the mag leaving the 2^AVG_LOG2-deep circular buffer.
- envelope_out = sum >> AVG_LOG2, registered, visible the cycle after the sample.
- The cycle after a valid sample is an "envelope update" (env_upd).
- burst_start_in clears the sum and buffer.

FSM states:
- IDLE: busy_out=0. burst_start_in -> BLANK.
- BLANK: detection ignored; echo_active_out forced 0; envelope still updates. At timer == BLANK_CYCLES -> LISTEN.
- LISTEN: on env_upd:
  - envelope ≥ THRESH_HI: hold_cnt++. If hold_cnt was 0, latch candidate = current timer.
  - envelope < THRESH_LO: hold_cnt = 0.
  - Otherwise: hold_cnt unchanged.
  - When hold_cnt reaches HOLD_SAMPLES -> CONVERT, with tof = candidate.
- echo_active_out (LISTEN only): set when envelope ≥ THRESH_HI, cleared when envelope < THRESH_LO.
- Timeout: timer == MAX_WAIT_CYCLES in BLANK or LISTEN -> no_echo_out pulses that cycle, then IDLE. tof/range outputs are unchanged. If confirmation and timeout occur in the same cycle, confirmation wins.
- CONVERT (2 cycles):
  - Cycle 1 registers the product tof × RANGE_MULT.
  - Cycle 2 computes product >> RANGE_SHIFT, saturated to 16'hFFFF; tof_cycles_out and range_out are loaded and valid_out pulses.
  - Then -> IDLE.
  - valid_out asserts 2 cycles after the confirming env_upd cycle.
- Only the first echo per burst is reported; later echoes are ignored until the next burst_start_in.
- burst_start_in in any non-IDLE state (including CONVERT) restarts at BLANK with timer 0. Any pending result is discarded: no valid_out or no_echo_out for the aborted burst.
- rst_in takes priority over burst_start_in.
- sample_valid_in outside a burst still updates envelope_out.

Test Plan:
Bench parameters for scenarios 2–6: AVG_LOG2=2, HOLD_SAMPLES=3, BLANK_CYCLES=10, MAX_WAIT_CYCLES=200, RANGE_MULT=1000, RANGE_SHIFT=4. Samples are valid every cycle.
1. Reset: assert rst_in for 3 cycles with random inputs -> all outputs 0, busy_out 0.
2. Normal echo: burst at cycle 0; samples 0 until cycle 50, then 8000.
   - Envelope reads 2000, 4000, 6000 at cycles 51, 52, 53.
   - Confirmed at 55; valid_out at 57 with tof_cycles_out=53 and range_out=3312.
   - busy_out falls at 58.
3. Blanking: samples 8000 for cycles 1–8, 0 until 50, then 8000 -> ring-down ignored; result identical to scenario 2.
4. Glitch then timeout: 8000 at cycles 50–51, then 0 -> envelope never reaches 3 consecutive ≥5000; no valid_out; no_echo_out at cycle 200; range_out retains its previous value.
5. Abort: scenario 2 with a second burst_start_in at cycle 56 -> no valid_out at 57; the new burst runs from timer 0 and times out at cycle 256.
6. Magnitude: scenario 2 with -8000 -> same result. Constant -32768 -> envelope_out 32767.
